instr_encoder_loader: RTL and testbench
=======================================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named `clk` and `reset_n`.
REQ-002 SHALL expose these ports (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous reset, active-low
- Start  input  1  begin load session
- BaseAddr  input  8  first instruction-memory address of the session
- InValid  input  1  instruction fields valid
- InReady  output  1  encoder accepts fields
- Opcode  input  2  instruction bits [7:6]
- Rd  input  3  register field, bits [5:3]
- Imm  input  8  immediate value
- ImmSel  input  1  0 = 3-bit immediate (sll/addi), 1 = 6-bit constant (jump)
- Last  input  1  final instruction of the session
- MemWrEn  output  1  instruction-memory write request
- MemAddr  output  8  write address
- MemData  output  8  encoded InstrCode
- MemAck  input  1  memory accepted the write this cycle
- Busy  output  1  session active
- Done  output  1  one-cycle session-complete pulse
- Err  output  1  sticky immediate-range error
- ErrCount  output  4  dropped-instruction count, saturating
- Count  output  8  instructions written, saturating
- Wrap  output  1  sticky flag: address wrapped 255->0

Function
REQ-003 SHALL implement the FSM states IDLE, ACCEPT, WRITE and DONE.
- IDLE: InReady=0, Busy=0.
- Start=1 in IDLE -> ACCEPT. Start=1 also loads the address register from BaseAddr and clears Count, Err, ErrCount and Wrap.
REQ-004 SHALL treat Start as ignored in ACCEPT, WRITE and DONE.
REQ-005 SHALL, in ACCEPT, drive InReady=1 and Busy=1; a transfer occurs when InValid and InReady are both 1 at a rising edge.
REQ-006 SHALL encode an accepted transfer as follows:
- ImmSel=0: MemData = {Opcode, Rd, Imm[2:0]}.
- ImmSel=1: MemData = {Opcode, Imm[5:0]}; Rd is ignored.
REQ-007 SHALL apply these range checks:
- ImmSel=0 with Imm[7:3] nonzero is a range error.
- ImmSel=1 with Imm[7:6] nonzero is a range error.
- An errored transfer is dropped: no write, Err set, ErrCount incremented and saturating at 15.
REQ-008 SHALL, on a valid transfer, register MemData and MemAddr and enter WRITE; MemWrEn=1 from the cycle after the transfer edge.
REQ-009 SHALL, in WRITE, hold MemWrEn, MemAddr and MemData stable with InReady=0 until MemAck=1. There is no timeout.
REQ-010 SHALL, on the MemWrEn and MemAck edge:
- increment the address modulo 256;
- increment Count, saturating at 255;
- go to DONE if the transfer had Last=1, else to ACCEPT.
REQ-011 SHALL set Wrap when the address increments from 255 to 0. Writing continues at address 0.
REQ-012 SHALL send an errored transfer with Last=1 directly from ACCEPT to DONE.
REQ-013 SHALL, in DONE, drive Done=1 for exactly one cycle and Busy=0, then return to IDLE. Count, Err, ErrCount and Wrap hold until the next Start.
REQ-014 SHALL drive MemWrEn=1 only in WRITE and InReady=1 only in ACCEPT; both SHALL never be 1 in the same cycle.
REQ-015 SHALL sustain a peak throughput of one instruction per 2 cycles (ACCEPT->WRITE->ACCEPT with MemAck tied high).

Reset
REQ-016 SHALL, while reset_n=0 (asynchronously, regardless of clk):
- force state IDLE;
- force InReady, MemWrEn, Busy, Done, Err and Wrap to 0;
- force MemAddr, MemData, Count and ErrCount to 0.
REQ-017 SHALL abort a write pending at reset assertion, with no retry after reset release.
REQ-018 SHALL resume operation on the first rising clk edge after reset_n deasserts.

Verification
REQ-019 Basic encode: BaseAddr=0x10, Start, then transfer Opcode=2'b01, Rd=3'b010, Imm=0x05, ImmSel=0, Last=1, MemAck=1.
- Expect one write: MemAddr=0x10, MemData=0x55.
- Then Done pulse, Count=1.
REQ-020 Jump encode with stall: Opcode=2'b11, Imm=0x2A, ImmSel=1, MemAck held 0 for 3 cycles.
- Expect MemData=0xEA held for 4 cycles with InReady=0 throughout.
REQ-021 Range error:
- Imm=0x09 with ImmSel=0 -> no write, Err=1, ErrCount=1.
- A following valid instruction is written at the unchanged address.
REQ-022 Wrap: BaseAddr=0xFE, 3 instructions -> addresses 0xFE, 0xFF, 0x00; Wrap=1, Count=3.
REQ-023 Reset mid-write: assert reset_n=0 in WRITE -> MemWrEn=0 immediately and all outputs 0; after release, a new Start session works normally.
REQ-024 Start ignored while Busy: pulse Start with BaseAddr=0x80 mid-session -> addresses continue the sequence and Count is not cleared.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Groups the instruction-loader handshake, session control and instruction-memory write bus.
// Latency: none; this is a signal bundle only.
// Backpressure: InReady throttles the instruction source; MemAck stalls the memory write.
// Ports: master = instruction source plus memory model (testbench side); slave = encoder/loader.
interface instr_encoder_loader_if;
   logic       Start;
   logic [7:0] BaseAddr;
   logic       InValid;
   logic       InReady;
   logic [1:0] Opcode;
   logic [2:0] Rd;
   logic [7:0] Imm;
   logic       ImmSel;
   logic       Last;
   logic       MemWrEn;
   logic [7:0] MemAddr;
   logic [7:0] MemData;
   logic       MemAck;
   logic       Busy;
   logic       Done;
   logic       Err;
   logic [3:0] ErrCount;
   logic [7:0] Count;
   logic       Wrap;

   modport master (
      output Start, BaseAddr, InValid, Opcode, Rd, Imm, ImmSel, Last, MemAck,
      input  InReady, MemWrEn, MemAddr, MemData, Busy, Done, Err, ErrCount, Count, Wrap
   );

   modport slave (
      input  Start, BaseAddr, InValid, Opcode, Rd, Imm, ImmSel, Last, MemAck,
      output InReady, MemWrEn, MemAddr, MemData, Busy, Done, Err, ErrCount, Count, Wrap
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes instruction fields into 8-bit InstrCode words and writes them to instruction memory.
// Latency: write request appears the cycle after the accepting edge; peak rate one instruction per 2 cycles.
// Backpressure: InReady is low while a write waits for MemAck; the write is held with no timeout.
// Ports: clk, reset_n (async active-low); bus (slave modport) carries session control, the
// instruction handshake (InValid/InReady + fields), the memory write port and status outputs.
module instr_encoder_loader (
   input logic                   clk,
   input logic                   reset_n,
   instr_encoder_loader_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic [7:0] addr_q;
   logic [7:0] data_q;
   logic [7:0] count_q;
   logic [3:0] errcnt_q;
   logic       err_q;
   logic       wrap_q;
   logic       last_q;

   logic       xfer;
   logic       range_err;
   logic       mem_done;
   logic [7:0] enc;

   assign xfer     = (state_q == ACCEPT) && bus.InValid;
   assign mem_done = (state_q == WRITE) && bus.MemAck;

   // Immediate must fit its field: 3 bits for sll/addi, 6 bits for jump.
   assign range_err = bus.ImmSel ? (bus.Imm[7:6] != 2'b00) : (bus.Imm[7:3] != 5'b00000);
   assign enc       = bus.ImmSel ? {bus.Opcode, bus.Imm[5:0]}
                                 : {bus.Opcode, bus.Rd, bus.Imm[2:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) state_d = ACCEPT;
         end
         ACCEPT: begin
            if (xfer) begin
               // A dropped instruction still honours Last so the session can close.
               if (range_err) state_d = bus.Last ? DONE : ACCEPT;
               else           state_d = WRITE;
            end
         end
         WRITE: begin
            if (bus.MemAck) state_d = last_q ? DONE : ACCEPT;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q   <= 8'd0;
         data_q   <= 8'd0;
         count_q  <= 8'd0;
         errcnt_q <= 4'd0;
         err_q    <= 1'b0;
         wrap_q   <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         if ((state_q == IDLE) && bus.Start) begin
            addr_q   <= bus.BaseAddr;
            count_q  <= 8'd0;
            errcnt_q <= 4'd0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
         end
         if (xfer) begin
            if (range_err) begin
               err_q <= 1'b1;
               if (errcnt_q != 4'hF) errcnt_q <= errcnt_q + 4'd1;
            end else begin
               data_q <= enc;
               last_q <= bus.Last;
            end
         end
         if (mem_done) begin
            addr_q <= addr_q + 8'd1;
            if (addr_q == 8'hFF)   wrap_q  <= 1'b1;
            if (count_q != 8'hFF)  count_q <= count_q + 8'd1;
         end
      end
   end

   // Strobes decode straight from the state register so reset clears them without a clock.
   assign bus.InReady  = (state_q == ACCEPT);
   assign bus.MemWrEn  = (state_q == WRITE);
   assign bus.Busy     = (state_q == ACCEPT) || (state_q == WRITE);
   assign bus.Done     = (state_q == DONE);
   assign bus.MemAddr  = addr_q;
   assign bus.MemData  = data_q;
   assign bus.Count    = count_q;
   assign bus.ErrCount = errcnt_q;
   assign bus.Err      = err_q;
   assign bus.Wrap     = wrap_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: scoreboard of expected memory writes.
// Latency: n/a (testbench).
// Backpressure: drives MemAck low to stall writes; waits on InReady before each transfer.
module tb_instr_encoder_loader;

   logic clk;
   logic reset_n;

   instr_encoder_loader_if bus ();

   instr_encoder_loader dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];
   logic [7:0]  exp_addr;
   logic [7:0]  exp_count;
   logic [3:0]  exp_errcnt;
   logic        exp_err;
   logic        exp_wrap;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write monitor: sampled 1 time unit after the falling edge, when inputs are settled.
   always @(negedge clk) begin
      #1;
      if (reset_n && bus.MemWrEn && bus.InReady) check("overlap", 1, 0);
      if (reset_n && bus.MemWrEn && bus.MemAck) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {bus.MemAddr, bus.MemData}, 0);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("write_addr", bus.MemAddr, e[15:8]);
            check("write_data", bus.MemData, e[7:0]);
         end
      end
   end

   task automatic start_session(input logic [7:0] base);
      bus.Start    = 1'b1;
      bus.BaseAddr = base;
      @(negedge clk);
      bus.Start    = 1'b0;
      exp_addr   = base;
      exp_count  = 8'd0;
      exp_errcnt = 4'd0;
      exp_err    = 1'b0;
      exp_wrap   = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input logic [2:0] rd, input logic [7:0] imm,
                       input logic sel, input logic last);
      int  i;
      logic bad;
      logic [7:0] d;
      i = 0;
      while (!bus.InReady && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (!bus.InReady) begin
         check("inready_timeout", 0, 1);
         return;
      end
      bus.Opcode  = op;
      bus.Rd      = rd;
      bus.Imm     = imm;
      bus.ImmSel  = sel;
      bus.Last    = last;
      bus.InValid = 1'b1;
      bad = sel ? (imm[7:6] != 2'b00) : (imm[7:3] != 5'b00000);
      d   = sel ? {op, imm[5:0]} : {op, rd, imm[2:0]};
      if (bad) begin
         exp_err = 1'b1;
         if (exp_errcnt != 4'hF) exp_errcnt++;
      end else begin
         exp_q.push_back({exp_addr, d});
         if (exp_addr == 8'hFF) exp_wrap = 1'b1;
         exp_addr++;
         if (exp_count != 8'hFF) exp_count++;
      end
      @(negedge clk);
      bus.InValid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int i;
      i = 0;
      while (!bus.Done && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (!bus.Done) begin
         check({tag, "_done_timeout"}, 0, 1);
         return;
      end
      check({tag, "_busy_in_done"}, bus.Busy, 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, bus.Done, 0);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_count"},    bus.Count,    exp_count);
      check({tag, "_err"},      bus.Err,      exp_err);
      check({tag, "_errcount"}, bus.ErrCount, exp_errcnt);
      check({tag, "_wrap"},     bus.Wrap,     exp_wrap);
      check({tag, "_queue"},    exp_q.size(), 0);
   endtask

   function automatic logic [63:0] all_outs();
      return {26'd0, bus.InReady, bus.MemWrEn, bus.Busy, bus.Done, bus.Err, bus.Wrap,
              bus.MemAddr, bus.MemData, bus.Count, bus.ErrCount};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.Start    = 1'b0;
      bus.BaseAddr = 8'd0;
      bus.InValid  = 1'b0;
      bus.Opcode   = 2'd0;
      bus.Rd       = 3'd0;
      bus.Imm      = 8'd0;
      bus.ImmSel   = 1'b0;
      bus.Last     = 1'b0;
      bus.MemAck   = 1'b1;
      exp_addr     = 8'd0;
      exp_count    = 8'd0;
      exp_errcnt   = 4'd0;
      exp_err      = 1'b0;
      exp_wrap     = 1'b0;
      reset_n      = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_inready", bus.InReady, 0);

      // Basic encode: 01_010_101 = 0x55 at 0x10.
      start_session(8'h10);
      check("accept_busy", bus.Busy, 1);
      send(2'b01, 3'b010, 8'h05, 1'b0, 1'b1);
      wait_done("basic");
      check_status("basic");

      // Jump encode with a 3-cycle MemAck stall: 11_101010 = 0xEA.
      start_session(8'h20);
      bus.MemAck = 1'b0;
      send(2'b11, 3'b111, 8'h2A, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("stall_wren",    bus.MemWrEn, 1);
         check("stall_data",    bus.MemData, 8'hEA);
         check("stall_addr",    bus.MemAddr, 8'h20);
         check("stall_inready", bus.InReady, 0);
         if (i == 3) bus.MemAck = 1'b1;
         @(negedge clk);
      end
      wait_done("stall");
      check_status("stall");

      // Range errors: dropped, address unchanged; errored Last closes the session.
      start_session(8'h30);
      send(2'b00, 3'b001, 8'h09, 1'b0, 1'b0);
      check("err_no_write", bus.MemWrEn, 0);
      check("err_flag",     bus.Err, 1);
      check("err_cnt1",     bus.ErrCount, 1);
      send(2'b10, 3'b011, 8'h07, 1'b0, 1'b0);
      send(2'b11, 3'b000, 8'h40, 1'b1, 1'b1);
      wait_done("err");
      check_status("err");

      // ErrCount saturates at 15.
      start_session(8'h50);
      for (int i = 0; i < 17; i++) send(2'b01, 3'b000, 8'hF0, 1'b0, (i == 16));
      wait_done("errsat");
      check_status("errsat");

      // Wrap at 0xFE: 0xFE, 0xFF, 0x00.
      start_session(8'hFE);
      for (int i = 0; i < 3; i++) send(i[1:0], 3'(i), 8'(i), 1'b0, (i == 2));
      wait_done("wrap");
      check_status("wrap");
      check("wrap_flag_set", bus.Wrap, 1);

      // Start ignored while busy.
      start_session(8'h40);
      send(2'b10, 3'b100, 8'h03, 1'b0, 1'b0);
      bus.Start    = 1'b1;
      bus.BaseAddr = 8'h80;
      send(2'b01, 3'b001, 8'h01, 1'b0, 1'b0);
      send(2'b00, 3'b010, 8'h02, 1'b0, 1'b1);
      bus.Start    = 1'b0;
      wait_done("start_ign");
      check_status("start_ign");

      // Count saturates at 255 across 257 back-to-back writes.
      start_session(8'h00);
      for (int i = 0; i < 257; i++) send(2'b11, 3'b000, 8'(i % 64), 1'b1, (i == 256));
      wait_done("cntsat");
      check_status("cntsat");

      // Reset in the middle of a stalled write.
      start_session(8'h60);
      bus.MemAck = 1'b0;
      send(2'b11, 3'b000, 8'h15, 1'b1, 1'b1);
      check("pre_reset_wren", bus.MemWrEn, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset_outputs", all_outs(), 0);
      exp_q.delete();
      @(negedge clk);
      reset_n    = 1'b1;
      bus.MemAck = 1'b1;
      @(negedge clk);
      check("no_retry_wren", bus.MemWrEn, 0);
      check("no_retry_busy", bus.Busy, 0);
      start_session(8'h61);
      send(2'b00, 3'b111, 8'h06, 1'b0, 1'b1);
      wait_done("post_reset");
      check_status("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
